// File: rtl/linebuf_scheduler_if.sv
// linebuf_scheduler_if
//   Pixel-side bundle of the line buffer scheduler: the input writer stream
//   and the output fetch handshake.
//   master : video input / VGA doubler side (drives strobes, takes fetched data)
//   slave  : linebuf_scheduler
//   Signals:
//     wr_valid, wr_data             input pixel strobe and pixel {b[1:0],g[2:0],r[2:0]}
//     rd_line_start                 start of next output line pass
//     rd_req                        fetch next pixel of current pass
//     rd_data, rd_data_valid        fetched pixel and its qualifier
//     line_avail                    a line is ready for its next pass
interface linebuf_scheduler_if #(
    parameter int DATA_W = 8
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              rd_line_start;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              line_avail;

    modport master (
        output wr_valid, wr_data, rd_line_start, rd_req,
        input  rd_data, rd_data_valid, line_avail
    );

    modport slave (
        input  wr_valid, wr_data, rd_line_start, rd_req,
        output rd_data, rd_data_valid, line_avail
    );
endinterface

// File: rtl/linebuf_scheduler.sv
// linebuf_scheduler
//   Ping-pong line buffer sequencer between the Donkey Kong video input and
//   the VGA frame doubler. Owns one single-port line RAM split into two banks,
//   arbitrates that port between the pixel writer (via a 1-deep skid) and the
//   output fetcher (via a 1-deep pending request), replays each stored line
//   LINE_REPEAT times, and keeps sticky overrun/underrun flags.
//   Ports:
//     masterclk    system clock, rising edge
//     rst          asynchronous active-high reset
//     px           pixel write / fetch bundle (linebuf_scheduler_if.slave)
//     ram_we       RAM write enable
//     ram_addr     {bank, pixel address}
//     ram_wdata    RAM write data
//     ram_rdata    RAM read data, synchronous with 1-cycle latency
//     clear_err    clears sticky error flags (a same-cycle set wins)
//     overrun      sticky: an input pixel was dropped
//     underrun     sticky: a fetch or line start found no line ready
module linebuf_scheduler #(
    parameter int LINE_WIDTH  = 256,
    parameter int DATA_W      = 8,
    parameter int LINE_REPEAT = 2,
    parameter int ADDR_W      = $clog2(LINE_WIDTH)
) (
    input  logic               masterclk,
    input  logic               rst,
    linebuf_scheduler_if.slave px,
    output logic               ram_we,
    output logic [ADDR_W:0]    ram_addr,
    output logic [DATA_W-1:0]  ram_wdata,
    input  logic [DATA_W-1:0]  ram_rdata,
    input  logic               clear_err,
    output logic               overrun,
    output logic               underrun
);
    localparam int PASS_W = (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(LINE_WIDTH - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(LINE_REPEAT - 1);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic GNT_READ  = 1'b0;
    localparam logic GNT_WRITE = 1'b1;

    logic [1:0]        bank_st   [2];
    logic [1:0]        bank_st_n [2];
    logic              wb, wb_n, rb, rb_n;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
    logic [PASS_W-1:0] pass_cnt, pass_cnt_n;
    logic              pass_act, pass_act_n;
    logic              skid_v, skid_v_n;
    logic [ADDR_W:0]   skid_addr, skid_addr_n;
    logic [DATA_W-1:0] skid_data, skid_data_n;
    logic              rd_pend, rd_pend_n;
    logic              last_grant, last_grant_n;
    logic              rd_vld_q, rd_vld_n;
    logic              rd_from_ram_q, rd_from_ram_n;
    logic              set_ovr, set_udr;

    logic              rd_active;
    logic              rd_ram;
    logic              rd_empty_srv;
    logic              gnt_w, gnt_r;

    // A pass is active only while the read bank drains and a line start has
    // opened the current pass.
    assign rd_active    = (bank_st[rb] == ST_DRAIN) && pass_act;
    assign rd_ram       = rd_pend && rd_active;
    // Pending fetch with no active pass is answered with zero data, no RAM use.
    assign rd_empty_srv = rd_pend && !rd_active;

    always_comb begin
        gnt_w = 1'b0;
        gnt_r = 1'b0;
        if (skid_v && rd_ram) begin
            gnt_r = (last_grant == GNT_WRITE);
            gnt_w = (last_grant == GNT_READ);
        end else begin
            gnt_w = skid_v;
            gnt_r = rd_ram;
        end
    end

    assign ram_we    = gnt_w;
    assign ram_addr  = gnt_w ? skid_addr : (gnt_r ? {rb, rd_ptr} : '0);
    assign ram_wdata = gnt_w ? skid_data : '0;

    assign px.rd_data_valid = rd_vld_q;
    assign px.rd_data       = rd_from_ram_q ? ram_rdata : '0;
    assign px.line_avail    = (bank_st[rb] == ST_FULL) ||
                              ((bank_st[rb] == ST_DRAIN) && !pass_act);

    // Write acceptance, read progress and line start are applied in that
    // order on the *_n copies, so a line start landing on the cycle a pass
    // ends acts on the already-advanced read bank.
    always_comb begin
        bank_st_n     = bank_st;
        wb_n          = wb;
        rb_n          = rb;
        wr_ptr_n      = wr_ptr;
        rd_ptr_n      = rd_ptr;
        pass_cnt_n    = pass_cnt;
        pass_act_n    = pass_act;
        skid_v_n      = skid_v && !gnt_w;
        skid_addr_n   = skid_addr;
        skid_data_n   = skid_data;
        // A request arriving while one is still held merges into it.
        rd_pend_n     = (rd_pend && rd_active && !gnt_r) || px.rd_req;
        last_grant_n  = gnt_w ? GNT_WRITE : (gnt_r ? GNT_READ : last_grant);
        rd_vld_n      = gnt_r || rd_empty_srv;
        rd_from_ram_n = gnt_r;
        set_ovr       = 1'b0;
        set_udr       = rd_empty_srv;

        if (px.wr_valid) begin
            // Skid may take a new pixel if it is empty or draining this cycle.
            if ((bank_st[wb] == ST_FULL) || (bank_st[wb] == ST_DRAIN) ||
                (skid_v && !gnt_w)) begin
                set_ovr = 1'b1;
            end else begin
                skid_v_n    = 1'b1;
                skid_addr_n = {wb, wr_ptr};
                skid_data_n = px.wr_data;
                if (bank_st[wb] == ST_EMPTY) begin
                    bank_st_n[wb] = ST_FILL;
                end
                if (wr_ptr == LAST_PIX) begin
                    bank_st_n[wb] = ST_FULL;
                    wb_n          = ~wb;
                    wr_ptr_n      = '0;
                end else begin
                    wr_ptr_n = wr_ptr + 1'b1;
                end
            end
        end

        if (gnt_r) begin
            if (rd_ptr == LAST_PIX) begin
                rd_ptr_n   = '0;
                pass_act_n = 1'b0;
                if (pass_cnt != LAST_PASS) begin
                    pass_cnt_n = pass_cnt + 1'b1;
                end else begin
                    bank_st_n[rb] = ST_EMPTY;
                    rb_n          = ~rb;
                    pass_cnt_n    = '0;
                end
            end else begin
                rd_ptr_n = rd_ptr + 1'b1;
            end
        end

        if (px.rd_line_start) begin
            if (bank_st_n[rb_n] == ST_FULL) begin
                bank_st_n[rb_n] = ST_DRAIN;
                pass_cnt_n      = '0;
                rd_ptr_n        = '0;
                pass_act_n      = 1'b1;
            end else if (bank_st_n[rb_n] == ST_DRAIN) begin
                // Opens the next pass, or restarts the current one from 0.
                rd_ptr_n   = '0;
                pass_act_n = 1'b1;
            end else begin
                set_udr = 1'b1;
            end
        end
    end

    always_ff @(posedge masterclk or posedge rst) begin
        if (rst) begin
            bank_st[0]    <= ST_EMPTY;
            bank_st[1]    <= ST_EMPTY;
            wb            <= 1'b0;
            rb            <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            pass_cnt      <= '0;
            pass_act      <= 1'b0;
            skid_v        <= 1'b0;
            skid_addr     <= '0;
            skid_data     <= '0;
            rd_pend       <= 1'b0;
            last_grant    <= GNT_READ;
            rd_vld_q      <= 1'b0;
            rd_from_ram_q <= 1'b0;
            overrun       <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            bank_st       <= bank_st_n;
            wb            <= wb_n;
            rb            <= rb_n;
            wr_ptr        <= wr_ptr_n;
            rd_ptr        <= rd_ptr_n;
            pass_cnt      <= pass_cnt_n;
            pass_act      <= pass_act_n;
            skid_v        <= skid_v_n;
            skid_addr     <= skid_addr_n;
            skid_data     <= skid_data_n;
            rd_pend       <= rd_pend_n;
            last_grant    <= last_grant_n;
            rd_vld_q      <= rd_vld_n;
            rd_from_ram_q <= rd_from_ram_n;
            if (set_ovr) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
            if (set_udr) begin
                underrun <= 1'b1;
            end else if (clear_err) begin
                underrun <= 1'b0;
            end
        end
    end
endmodule
